// File: rtl/line_ram_buf.sv
// Double-buffered 160-entry line RAM: DMA fills the write bank while scan-out reads the display bank.
// Reads are registered (1 cycle); banks exchange on lram_swap, and the vacated display bank's valid bitmap is cleared in one edge.
module line_ram_buf #(
  parameter int NPIX = 160,
  parameter int PW   = 5
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          enable,
  input  logic          kangaroo,
  input  logic          wr_en,
  input  logic [7:0]    wr_addr,
  input  logic [PW-1:0] wr_data,
  input  logic          lram_swap,
  input  logic [7:0]    rd_addr,
  output logic [PW-1:0] rd_data,
  output logic          rd_bg,
  output logic          disp_bank,
  output logic          wr_drop
);

  localparam logic [7:0] NPIX_L = 8'(NPIX);

  logic          bank_sel;
  logic [PW-1:0] mem   [2][NPIX];
  logic [NPIX-1:0] valid [2];

  logic          wb;
  logic          db;
  logic          wr_hit;
  logic          wr_ok;
  logic          wr_oor;
  logic          wr_opaque;
  logic          swap_ok;
  logic [7:0]    rd_idx;
  logic          rd_hit;
  logic [PW-1:0] rd_word;

  assign wb        = bank_sel;
  assign db        = ~bank_sel;
  assign disp_bank = db;

  assign wr_hit    = enable & wr_en;
  assign wr_ok     = wr_hit & (wr_addr < NPIX_L);
  assign wr_oor    = wr_hit & ~(wr_addr < NPIX_L);
  assign wr_opaque = (wr_data[1:0] != 2'b00);
  assign swap_ok   = enable & lram_swap;

  // Out-of-range reads are steered to entry 0 so the array is never indexed past its end.
  assign rd_idx  = (rd_addr < NPIX_L) ? rd_addr : 8'd0;
  assign rd_hit  = enable & (rd_addr < NPIX_L) & valid[db][rd_idx];
  assign rd_word = mem[db][rd_idx];

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      bank_sel <= 1'b0;
      valid[0] <= '0;
      valid[1] <= '0;
      rd_data  <= '0;
      rd_bg    <= 1'b1;
      wr_drop  <= 1'b0;
    end else begin
      wr_drop <= wr_oor;
      // Color 0 is transparent unless kangaroo mode turns it into an erase.
      if (wr_ok && (wr_opaque || kangaroo))
        valid[wb][wr_addr] <= wr_opaque;
      // The write above always targets the other bank, so the two never collide.
      if (swap_ok) begin
        bank_sel  <= ~bank_sel;
        valid[db] <= '0;
      end
      rd_data <= rd_hit ? rd_word : '0;
      rd_bg   <= rd_hit ? (rd_word[1:0] == 2'b00) : 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (wr_ok && wr_opaque)
      mem[wb][wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_line_ram_buf.sv
// Directed bench for line_ram_buf: driver queues hand-computed expectations, monitor compares after each edge.
module tb_line_ram_buf;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       enable;
  logic       kangaroo;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [4:0] wr_data;
  logic       lram_swap;
  logic [7:0] rd_addr;
  logic [4:0] rd_data;
  logic       rd_bg;
  logic       disp_bank;
  logic       wr_drop;

  typedef struct packed {
    logic [4:0] data;
    logic       bg;
    logic       drop;
    logic       disp;
    logic [7:0] ra;
    logic [7:0] id;
  } exp_t;

  exp_t exp_q[$];
  exp_t due_q[$];
  int   nvec = 0;
  int   nerr = 0;

  line_ram_buf #(.NPIX(160), .PW(5)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .enable    (enable),
    .kangaroo  (kangaroo),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .lram_swap (lram_swap),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_bg     (rd_bg),
    .disp_bank (disp_bank),
    .wr_drop   (wr_drop)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string nm, input logic [7:0] id, input logic [7:0] ra,
                     input logic [7:0] got, input logic [7:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s test%0d addr=%0d: got %0h expected %0h", nm, id, ra, got, want);
    end
  endtask

  // Expectations issued before an edge become due once that edge has happened.
  always @(posedge sysclk) begin
    while (exp_q.size() > 0) due_q.push_back(exp_q.pop_front());
  end

  always @(negedge sysclk) begin
    exp_t e;
    if (due_q.size() > 0) begin
      e = due_q.pop_front();
      chk("rd_data",   e.id, e.ra, {3'b0, rd_data}, {3'b0, e.data});
      chk("rd_bg",     e.id, e.ra, {7'b0, rd_bg},     {7'b0, e.bg});
      chk("wr_drop",   e.id, e.ra, {7'b0, wr_drop},   {7'b0, e.drop});
      chk("disp_bank", e.id, e.ra, {7'b0, disp_bank}, {7'b0, e.disp});
    end
  end

  task automatic cyc(input bit en, input bit kg, input bit we, input logic [7:0] wa,
                     input logic [4:0] wd, input bit sw, input logic [7:0] ra,
                     input logic [4:0] ed, input bit eb, input bit edrop, input bit edisp,
                     input logic [7:0] id);
    exp_t e;
    enable = en; kangaroo = kg; wr_en = we; wr_addr = wa; wr_data = wd;
    lram_swap = sw; rd_addr = ra;
    e.data = ed; e.bg = eb; e.drop = edrop; e.disp = edisp; e.ra = ra; e.id = id;
    exp_q.push_back(e);
    @(negedge sysclk);
  endtask

  task automatic rd(input logic [7:0] ra, input logic [4:0] ed, input bit eb,
                    input bit edisp, input logic [7:0] id);
    cyc(1, 0, 0, 8'd0, 5'd0, 0, ra, ed, eb, 0, edisp, id);
  endtask

  task automatic wr(input logic [7:0] wa, input logic [4:0] wd, input bit kg,
                    input bit edrop, input bit edisp, input logic [7:0] id);
    cyc(1, kg, 1, wa, wd, 0, 8'd200, 5'd0, 1, edrop, edisp, id);
  endtask

  task automatic swp(input bit edisp, input logic [7:0] id);
    cyc(1, 0, 0, 8'd0, 5'd0, 1, 8'd200, 5'd0, 1, 0, edisp, id);
  endtask

  function automatic logic [4:0] fill_val(input int a);
    return {3'(a >> 2), 2'((a % 3) + 1)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; kangaroo = 1'b0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; lram_swap = 1'b0; rd_addr = '0;
    repeat (2) @(negedge sysclk);
    chk("reset_rd_data",   8'd0, 8'd0, {3'b0, rd_data}, 8'h00);
    chk("reset_rd_bg",     8'd0, 8'd0, {7'b0, rd_bg},     8'h01);
    chk("reset_wr_drop",   8'd0, 8'd0, {7'b0, wr_drop},   8'h00);
    chk("reset_disp_bank", 8'd0, 8'd0, {7'b0, disp_bank}, 8'h01);
    reset = 1'b0;
    @(negedge sysclk);

    // 1: everything reads as background after reset
    for (int a = 0; a < 160; a++) rd(8'(a), 5'd0, 1, 1, 8'd1);
    rd(8'd255, 5'd0, 1, 1, 8'd1);

    // 2: write, swap, read back
    wr(8'd10, 5'b10110, 0, 0, 1, 8'd2);
    swp(0, 8'd2);
    rd(8'd10, 5'b10110, 0, 0, 8'd2);
    rd(8'd11, 5'd0, 1, 0, 8'd2);

    // 3: transparent color 0, then kangaroo erase
    wr(8'd20, 5'b01101, 0, 0, 0, 8'd3);
    wr(8'd20, 5'b11100, 0, 0, 0, 8'd3);
    swp(1, 8'd3);
    rd(8'd20, 5'b01101, 0, 1, 8'd3);
    rd(8'd10, 5'd0, 1, 1, 8'd3);
    wr(8'd20, 5'b01101, 0, 0, 1, 8'd3);
    wr(8'd21, 5'b00111, 0, 0, 1, 8'd3);
    wr(8'd20, 5'b11100, 1, 0, 1, 8'd3);
    swp(0, 8'd3);
    rd(8'd20, 5'd0, 1, 0, 8'd3);
    rd(8'd21, 5'b00111, 0, 0, 8'd3);

    // 4: out-of-range writes drop, last legal column still works
    wr(8'd160, 5'b11111, 0, 1, 0, 8'd4);
    rd(8'd200, 5'd0, 1, 0, 8'd4);
    wr(8'd255, 5'b11010, 0, 1, 0, 8'd4);
    rd(8'd200, 5'd0, 1, 0, 8'd4);
    wr(8'd159, 5'b00001, 0, 0, 0, 8'd4);
    swp(1, 8'd4);
    rd(8'd0,   5'd0, 1, 1, 8'd4);
    rd(8'd95,  5'd0, 1, 1, 8'd4);
    rd(8'd159, 5'b00001, 0, 1, 8'd4);
    rd(8'd160, 5'd0, 1, 1, 8'd4);

    // 5: fill a bank, display it, then swap it away and clear it
    for (int a = 0; a < 160; a++) wr(8'(a), fill_val(a), 0, 0, 1, 8'd5);
    swp(0, 8'd5);
    for (int a = 0; a < 160; a++) rd(8'(a), fill_val(a), 0, 0, 8'd5);
    swp(1, 8'd5);
    for (int a = 0; a < 160; a += 7) rd(8'(a), 5'd0, 1, 1, 8'd5);
    swp(0, 8'd5);
    swp(1, 8'd5);
    rd(8'd0, 5'd0, 1, 1, 8'd5);

    // 6: write in the swap cycle lands in the new display bank; same-cycle read sees the old one
    cyc(1, 0, 1, 8'd5, 5'b10101, 1, 8'd5, 5'd0, 1, 0, 0, 8'd6);
    rd(8'd5, 5'b10101, 0, 0, 8'd6);

    // 7: disabled swap/read/write are ignored and contents are held
    cyc(0, 0, 0, 8'd0, 5'd0, 1, 8'd5, 5'd0, 1, 0, 0, 8'd7);
    cyc(0, 0, 1, 8'd200, 5'b11111, 0, 8'd5, 5'd0, 1, 0, 0, 8'd7);
    rd(8'd5, 5'b10101, 0, 0, 8'd7);

    // 8: asynchronous reset mid-cycle
    enable = 1'b1; wr_en = 1'b0; lram_swap = 1'b0; rd_addr = 8'd5;
    #2 reset = 1'b1;
    #1;
    chk("arst_rd_data",   8'd8, 8'd5, {3'b0, rd_data}, 8'h00);
    chk("arst_rd_bg",     8'd8, 8'd5, {7'b0, rd_bg},     8'h01);
    chk("arst_disp_bank", 8'd8, 8'd5, {7'b0, disp_bank}, 8'h01);
    reset = 1'b0;
    @(negedge sysclk);
    rd(8'd5, 5'd0, 1, 1, 8'd8);
    swp(0, 8'd8);
    rd(8'd5, 5'd0, 1, 0, 8'd8);

    enable = 1'b0; wr_en = 1'b0; lram_swap = 1'b0;
    repeat (2) @(negedge sysclk);
    nvec++;
    if (exp_q.size() != 0 || due_q.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size() + due_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/line_ram_buf.md
# line_ram_buf

Double-buffered MARIA line RAM between the DMA write path and the VGA scan-out path. One bank (write bank) is filled by display-list DMA with 160 pixel entries while the other (display bank) is read at pixel rate by the VGA output stage. The banks exchange roles on the single-cycle `lram_swap` pulse issued by the timing controller. Each bank carries a per-pixel valid bitmap so the new write bank is cleared in one cycle at swap instead of by a sweep.

## Interface
Parameters:
- `NPIX`, 160: entries per bank; legal addresses are 0..NPIX-1.
- `PW`, 5: entry width, {palette[2:0], color[1:0]}.

Ports:
- `sysclk`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  MARIA DMA enable (CTRL).
- `kangaroo`  in  1  kangaroo mode: color-0 writes are not transparent.
- `wr_en`  in  1  DMA pixel write strobe.
- `wr_addr`  in  8  pixel column of write.
- `wr_data`  in  PW  {palette, color} of write.
- `lram_swap`  in  1  one-cycle swap request from timing_ctrl.
- `rd_addr`  in  8  pixel column to read (vga_col/4).
- `rd_data`  out  PW  entry at `rd_addr` of display bank; 0 when invalid.
- `rd_bg`  out  1  1 = show background color (invalid entry, or color==0).
- `disp_bank`  out  1  index of current display bank (debug/verification).
- `wr_drop`  out  1  one-cycle pulse: a write was discarded for an out-of-range address.

## Operation
- State: `bank_sel` (write bank = `bank_sel`, display bank = `~bank_sel`), storage `mem[2][NPIX]` of PW bits, bitmap `valid[2][NPIX]`.
- `disp_bank` = `~bank_sel`.
- Write accepted when `enable & wr_en & wr_addr < NPIX`:
  - `wr_data[1:0] != 0`: `mem[wb][wr_addr] <= wr_data`, `valid[wb][wr_addr] <= 1`.
  - `wr_data[1:0] == 0`, `kangaroo=0`: transparent. No state change.
  - `wr_data[1:0] == 0`, `kangaroo=1`: `valid[wb][wr_addr] <= 0`, so an earlier object pixel is erased to background.
- `enable & wr_en & wr_addr >= NPIX`: write discarded, `wr_drop` pulses next cycle. There is no wrap-around.
- Later writes to the same address overwrite earlier ones. Last writer wins, within a line and within a cycle ordering.
- Swap when `enable & lram_swap`:
  - `bank_sel <= ~bank_sel`.
  - All `valid[~bank_sel_old]` bits are cleared on the same edge. This is the old display bank, which becomes the new write bank.
  - The old write bank becomes the display bank with contents intact.
- `lram_swap` while `enable=0` is ignored.
- Read: registered.
  - `rd_addr < NPIX` and `valid[db][rd_addr]`: `rd_data <= mem[db][rd_addr]`, `rd_bg <= (mem[db][rd_addr][1:0]==0)`.
  - Otherwise: `rd_data <= 0`, `rd_bg <= 1`.
  - When `enable=0` the read returns `rd_data=0`, `rd_bg=1`.

## Timing
- Reset values:
  - `bank_sel=0`, so `disp_bank=1`.
  - All `valid` bits = 0.
  - `rd_data=0`, `rd_bg=1`, `wr_drop=0`.
  - `mem` contents need no reset.
- Write latency: a write at edge N is visible to a read sampled at edge N+1. `rd_data` shows it after edge N+1 only if that bank is the display bank.
- Read latency: 1 cycle, `rd_addr` at edge N gives `rd_data` valid after edge N.
- Write in the same cycle as a swap goes to the pre-swap write bank, which becomes display. That pixel is displayed on the next line and is not cleared.
- Read in the same cycle as a swap uses the pre-swap display bank. Reads from edge N+1 use the new bank.
- Swaps on consecutive cycles each toggle. Each swap clears the bank being vacated by display.
- Reset asserted mid-line: all state returns to reset values immediately (asynchronous). The line in progress is lost, both banks read as background.
- `enable` falling mid-line: contents and `bank_sel` are held. Reads give background. Writes and swaps are ignored until `enable` returns.

## Test plan
1. Reset, read addr 0..159 → `rd_bg=1`, `rd_data=0` everywhere; `disp_bank=1`.
2. Write addr 10 = 5'b10110, then swap, then read addr 10 → `rd_data=5'b10110`, `rd_bg=0` one cycle after the read address is presented. Addr 11 → `rd_bg=1`.
3. Write addr 20 = 5'b01101, then at addr 20 write 5'b11100 with `kangaroo=0`, then swap → reads 5'b01101. Repeat with `kangaroo=1` → reads `rd_bg=1`, `rd_data=0`.
4. Write addr 160 and addr 255 → `wr_drop` pulses once each; no entry changes.
5. Fill write bank, then swap twice → the second swap clears the displayed bank; reads all `rd_bg=1`.
6. Write addr 5 in the same cycle as `lram_swap` → the value is readable from the new display bank on the next cycle.
7. `enable=0` with `lram_swap` pulse → `disp_bank` unchanged, reads background.
